// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// the store byte-enable helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, RESP} state_e;

  // Byte lanes written by a store; unsupported funct3 writes nothing.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (f3)
      F3_B:    be = 4'b0001 << off;
      F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Combinational load formatter: picks the byte/halfword/word addressed by the
// registered offset and sign- or zero-extends it.
module lsu_ld_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  bt;
  logic [15:0] hw;

  always_comb begin
    bt = 8'h00;
    case (i_off)
      2'd0: bt = i_word[7:0];
      2'd1: bt = i_word[15:8];
      2'd2: bt = i_word[23:16];
      2'd3: bt = i_word[31:24];
      default: bt = 8'h00;
    endcase
    hw = i_off[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = 32'h0;
    case (i_funct3)
      F3_B:    o_data = {{24{bt[7]}}, bt};
      F3_H:    o_data = {{16{hw[15]}}, hw};
      F3_W:    o_data = i_word;
      F3_BU:   o_data = {24'h0, bt};
      F3_HU:   o_data = {16'h0, hw};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit with synchronous word-addressed data RAM; loads respond one
// cycle after acceptance. Define LSU_MISALIGN_CHK_EN to reject misaligned H/W accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter  int DEPTH_WORDS = 2048,
  localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rden,
  input  logic        i_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_ld_data,
  output logic        o_ld_valid,
  output logic        o_misaligned
);

  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic              misal;
  logic              ld_acc;
  logic [3:0]        st_be;
  logic [31:0]       wdata;
  logic [31:0]       fmt;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        misal_q, misal_d;
  logic [31:0] rd_word_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Address bits above the RAM are deliberately ignored (address wraps).
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_addr[31:ADDR_W+2];

  assign idx = i_addr[ADDR_W+1:2];
  assign off = i_addr[1:0];

`ifdef LSU_MISALIGN_CHK_EN
  always_comb begin
    misal = 1'b0;
    if (i_wren)
      misal = ((i_funct3 == F3_H) && off[0]) || ((i_funct3 == F3_W) && (off != 2'b00));
    else if (i_rden)
      misal = (((i_funct3 == F3_H) || (i_funct3 == F3_HU)) && off[0]) ||
              ((i_funct3 == F3_W) && (off != 2'b00));
  end
`else
  assign misal = 1'b0;
`endif

  // A simultaneous store wins; the load half is dropped without a response.
  assign ld_acc = i_rden && !i_wren && !misal;
  assign st_be  = (i_wren && !misal) ? byte_en(i_funct3, off) : 4'b0000;

  always_comb begin
    wdata = i_st_data;
    case (i_funct3)
      F3_B:    wdata = {4{i_st_data[7:0]}};
      F3_H:    wdata = {2{i_st_data[15:0]}};
      default: wdata = i_st_data;
    endcase
  end

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++)
      if (st_be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    if (ld_acc) rd_word_q <= mem[idx];
  end

  lsu_ld_align u_align (
    .i_word   (rd_word_q),
    .i_off    (off_q),
    .i_funct3 (f3_q),
    .o_data   (fmt)
  );

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = ld_acc ? RESP : IDLE;
      RESP:    state_d = ld_acc ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
    off_d     = ld_acc ? off : off_q;
    f3_d      = ld_acc ? i_funct3 : f3_q;
    ld_data_d = (state_q == RESP) ? fmt : ld_data_q;
    misal_d   = misal;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      ld_data_q <= 32'h0;
      misal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      f3_q      <= f3_d;
      ld_data_q <= ld_data_d;
      misal_q   <= misal_d;
    end
  end

  // Live formatted data during RESP, last response held otherwise.
  assign o_ld_valid   = (state_q == RESP);
  assign o_ld_data    = (state_q == RESP) ? fmt : ld_data_q;
  assign o_misaligned = misal_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: table of requests with expected responses fed
// through a scoreboard queue, plus a reset-during-response sequence.
module tb_lsu;
  import lsu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_rden = 1'b0;
  logic        i_wren = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_st_data = 32'h0;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;
  logic        o_misaligned;

  lsu #(.DEPTH_WORDS(2048)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rden       (i_rden),
    .i_wren       (i_wren),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_st_data    (i_st_data),
    .o_ld_data    (o_ld_data),
    .o_ld_valid   (o_ld_valid),
    .o_misaligned (o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] st;
    logic        vld;
    logic [31:0] data;
    logic        mis;
  } vec_t;

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic        mis;
    int          id;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_data = 32'h0;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] st,
                              input logic vld, input logic [31:0] data, input logic mis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.st = st;
    v.vld = vld; v.data = data; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("vld#%0d", e.id), {31'b0, o_ld_valid}, {31'b0, e.vld});
      if (e.vld) last_data = e.data;
      chk($sformatf("data#%0d", e.id), o_ld_data, last_data);
      chk($sformatf("mis#%0d", e.id), {31'b0, o_misaligned}, {31'b0, e.mis});
    end
  endtask

  task automatic drive_idle();
    i_rden = 1'b0; i_wren = 1'b0; i_funct3 = 3'b000; i_addr = 32'h0; i_st_data = 32'h0;
  endtask

  task automatic cyc(input vec_t v, input int id);
    exp_t e;
    @(negedge i_clk);
    check_pop();
    i_rden = v.rd; i_wren = v.wr; i_funct3 = v.f3; i_addr = v.addr; i_st_data = v.st;
    e.vld = v.vld; e.data = v.data; e.mis = v.mis; e.id = id;
    sb.push_back(e);
  endtask

  task automatic flush();
    while (sb.size() > 0) begin
      @(negedge i_clk);
      check_pop();
      drive_idle();
    end
  endtask

  initial begin
    // rd wr f3 addr st | vld data mis
    tbl.push_back(mk(0, 1, F3_W,  32'h14,   32'h0000_0000, 0, 32'h0, 0));
    tbl.push_back(mk(0, 1, F3_W,  32'h10,   32'hDEAD_BEEF, 0, 32'h0, 0));
    tbl.push_back(mk(1, 0, F3_W,  32'h10,   32'h0,         1, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(1, 0, F3_B,  32'h13,   32'h0,         1, 32'hFFFF_FFDE, 0));
    tbl.push_back(mk(1, 0, F3_BU, 32'h13,   32'h0,         1, 32'h0000_00DE, 0));
    tbl.push_back(mk(1, 0, F3_H,  32'h12,   32'h0,         1, 32'hFFFF_DEAD, 0));
    tbl.push_back(mk(1, 0, F3_HU, 32'h10,   32'h0,         1, 32'h0000_BEEF, 0));
    tbl.push_back(mk(0, 1, F3_B,  32'h11,   32'hFFFF_FF55, 0, 32'h0, 0));
    tbl.push_back(mk(1, 0, F3_W,  32'h10,   32'h0,         1, 32'hDEAD_55EF, 0));
    tbl.push_back(mk(0, 1, F3_H,  32'h12,   32'hABCD_1234, 0, 32'h0, 0));
    tbl.push_back(mk(1, 0, F3_W,  32'h10,   32'h0,         1, 32'h1234_55EF, 0));
    tbl.push_back(mk(1, 0, F3_W,  32'h14,   32'h0,         1, 32'h0000_0000, 0));
    tbl.push_back(mk(0, 0, F3_W,  32'h10,   32'h0,         0, 32'h0, 0));
    tbl.push_back(mk(1, 0, F3_B,  32'h10,   32'h0,         1, 32'hFFFF_FFEF, 0));
    tbl.push_back(mk(1, 0, F3_H,  32'h10,   32'h0,         1, 32'h0000_55EF, 0));
    tbl.push_back(mk(1, 0, F3_W,  32'h2010, 32'h0,         1, 32'h1234_55EF, 0));
    tbl.push_back(mk(1, 0, 3'b011, 32'h10,  32'h0,         1, 32'h0000_0000, 0));
    tbl.push_back(mk(1, 1, F3_W,  32'h18,   32'hAAAA_5555, 0, 32'h0, 0));
    tbl.push_back(mk(1, 0, F3_W,  32'h18,   32'h0,         1, 32'hAAAA_5555, 0));
    tbl.push_back(mk(0, 1, 3'b011, 32'h18,  32'h0,         0, 32'h0, 0));
    tbl.push_back(mk(1, 0, F3_W,  32'h18,   32'h0,         1, 32'hAAAA_5555, 0));
    tbl.push_back(mk(1, 0, 3'b110, 32'h18,  32'h0,         1, 32'h0000_0000, 0));
`ifdef LSU_MISALIGN_CHK_EN
    tbl.push_back(mk(1, 0, F3_W,  32'h11,   32'h0,         0, 32'h0, 1));
    tbl.push_back(mk(0, 1, F3_H,  32'h13,   32'h0000_FFFF, 0, 32'h0, 1));
    tbl.push_back(mk(1, 0, F3_HU, 32'h11,   32'h0,         0, 32'h0, 1));
    tbl.push_back(mk(1, 0, F3_W,  32'h10,   32'h0,         1, 32'h1234_55EF, 0));
    tbl.push_back(mk(1, 0, F3_BU, 32'h11,   32'h0,         1, 32'h0000_0055, 0));
`else
    tbl.push_back(mk(1, 0, F3_W,  32'h11,   32'h0,         1, 32'h1234_55EF, 0));
    tbl.push_back(mk(1, 0, F3_H,  32'h13,   32'h0,         1, 32'h0000_1234, 0));
    tbl.push_back(mk(1, 0, F3_HU, 32'h11,   32'h0,         1, 32'h0000_55EF, 0));
`endif

    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    chk("rst_vld",  {31'b0, o_ld_valid},   32'h0);
    chk("rst_data", o_ld_data,             32'h0);
    chk("rst_mis",  {31'b0, o_misaligned}, 32'h0);

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], i);
    flush();

    // Reset while a response is being presented: valid must drop at once.
    @(negedge i_clk);
    i_rden = 1'b1; i_funct3 = F3_W; i_addr = 32'h10;
    @(posedge i_clk);
    #1;
    chk("resp_vld", {31'b0, o_ld_valid}, 32'h1);
    chk("resp_data", o_ld_data, 32'h1234_55EF);
    drive_idle();
    i_reset = 1'b0;
    #1;
    chk("arst_vld",  {31'b0, o_ld_valid}, 32'h0);
    chk("arst_data", o_ld_data,           32'h0);
    @(negedge i_clk);
    i_reset = 1'b1;
    last_data = 32'h0;

    cyc(mk(1, 0, F3_W, 32'h10, 32'h0, 1, 32'h1234_55EF, 0), 100);
    cyc(mk(0, 0, F3_W, 32'h0,  32'h0, 0, 32'h0, 0), 101);
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit and data memory for the RV32I core. It is the responder side of the one-cycle load stall the PC register applies: the PC holds for one cycle on a load, and this block returns load data exactly one cycle after accepting the request. It holds a synchronous word-addressed data RAM, applies byte-lane write masks for SB/SH/SW, and aligns and extends read data for LB/LH/LW/LBU/LHU.

## Interface
Parameters:
- DEPTH_WORDS, 2048, data RAM depth in 32-bit words; power of two.
- ADDR_W, $clog2(DEPTH_WORDS), word-index width (derived, not overridden).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rden  in  1  load request this cycle.
- i_wren  in  1  store request this cycle.
- i_funct3  in  3  access size/sign, RV32I funct3 encoding.
- i_addr  in  32  byte address (ALU result).
- i_st_data  in  32  store data (rs2); low bytes used for SB/SH.
- o_ld_data  out  32  aligned, extended load data; valid when o_ld_valid.
- o_ld_valid  out  1  one-cycle pulse, load response.
- o_misaligned  out  1  one-cycle pulse, rejected access (see Configuration).

## Operation
- Word index = i_addr[ADDR_W+1:2]; higher address bits are ignored (wraps mod DEPTH_WORDS*4).
- FSM states: IDLE, RESP. IDLE + accepted load -> RESP. RESP + accepted load -> RESP (back-to-back). RESP otherwise -> IDLE. o_ld_valid = (state == RESP).
- Load accept: i_rden=1, i_wren=0, access legal. Registers word index, i_addr[1:0], i_funct3; RAM read is synchronous.
- Load formatting in RESP, from registered offset/funct3: 000 LB byte sign-extended; 001 LH halfword at offset[1] sign-extended; 010 LW; 100 LBU, 101 LHU zero-extended. 011/110/111: o_ld_data = 0, o_ld_valid still pulses.
- Store: i_wren=1 writes on that edge with byte enables: SB one lane at addr[1:0], st_data[7:0] replicated; SH lanes {1,0} or {3,2} by addr[1]; SW all lanes. Unsupported funct3: no write.
- i_rden and i_wren together: store performed, load ignored, no response.
- Store followed next cycle by a load of the same word returns the new data (write lands before read).
- o_ld_data holds its last value outside RESP.

## Timing
- Reset: state IDLE, o_ld_valid=0, o_misaligned=0, o_ld_data=0, registered offset/funct3 = 0. RAM contents not reset.
- Load latency: request on edge N, o_ld_valid and o_ld_data valid in the cycle after edge N, for exactly one cycle.
- Store latency: visible to any load accepted on or after edge N+1.
- Throughput: one access per cycle, no backpressure.
- Reset asserted during RESP: o_ld_valid drops immediately (asynchronously); pending response lost.
- o_misaligned registered: pulses the cycle after the offending request, same timing as o_ld_valid.

## Configuration
- LSU_MISALIGN_CHK_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, are rejected: no RAM write, no load response, o_misaligned pulses one cycle.
- Undefined: no check; o_misaligned tied 0; halfword uses addr[1] only, word ignores addr[1:0] (force-aligned).

## Structure
- lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum {IDLE, RESP}, byte-enable function.
- Sub-module lsu_ld_align: combinational; raw word + offset + funct3 -> formatted load data.
- RAM inferred inline as a reg array with per-byte write enables.

## Test plan
- Reset then SW 0xDEADBEEF to 0x10, LW 0x10 next cycle -> o_ld_valid one cycle later, o_ld_data=0xDEADBEEF.
- LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF; SH 0x1234 to 0x12, LW 0x10 -> 0x123455EF.
- Back-to-back LW 0x10, LW 0x14 (0x14 holds 0) on consecutive cycles -> o_ld_valid high two cycles, data 0x123455EF then 0x00000000.
- With LSU_MISALIGN_CHK_EN: LW 0x11 -> o_misaligned pulse, no o_ld_valid; SH to 0x13 -> memory unchanged. Without it: LW 0x11 -> 0x123455EF.
- Assert i_reset low during RESP -> o_ld_valid=0 immediately; after release, LW 0x10 still returns 0x123455EF.
